// File: rtl/audio_deserializer_if.sv
// Codec stream in, parallel sample and status pulses out.
// The deserializer sits on the slave side; the codec/test side uses master.
interface audio_deserializer_if #(
   parameter int SAMPLE_WIDTH = 16
);
   logic                    enable;
   logic                    bitClk;
   logic                    lrClk;
   logic                    serialIn;
   logic [SAMPLE_WIDTH-1:0] sample;
   logic                    desDone;
   logic                    frameError;

   modport master (
      output enable, bitClk, lrClk, serialIn,
      input  sample, desDone, frameError
   );

   modport slave (
      input  enable, bitClk, lrClk, serialIn,
      output sample, desDone, frameError
   );
endinterface

// File: rtl/audio_deserializer.sv
// I2S mono capture: waits for the capture-channel frame edge, discards the
// one-bit I2S delay slot, shifts SAMPLE_WIDTH bits MSB first and presents
// the word with a one-cycle desDone pulse. An early frame edge aborts the
// word with a one-cycle frameError pulse and resynchronises immediately.
module audio_deserializer #(
   parameter int SAMPLE_WIDTH = 16,
   parameter bit LEFT_CHANNEL = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   audio_deserializer_if.slave bus
);
   localparam int               W          = SAMPLE_WIDTH;
   localparam int               CNT_W      = $clog2(SAMPLE_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SAMPLE_WIDTH - 1);
   // lrClk level that marks the word we capture (left word has lrClk low)
   localparam logic             CAPTURE_LR = !LEFT_CHANNEL;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SKIP, ST_SHIFT} state_t;

   state_t           state_q, state_d;
   logic             bit_clk_q;
   logic             lr_prev_q, lr_prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     shift_q, shift_d;
   logic [W-1:0]     sample_q, sample_d;
   logic             des_done_q, des_done_d;
   logic             frame_error_q, frame_error_d;

   logic             bit_rise;
   logic             frame_edge;
   logic             word_done;
   logic [W-1:0]     shifted;

   assign bit_rise   = bus.bitClk & ~bit_clk_q;
   assign frame_edge = bit_rise & (lr_prev_q != bus.lrClk) & (bus.lrClk == CAPTURE_LR);
   assign word_done  = bit_rise & (cnt_q == LAST_CNT);
   assign shifted    = {shift_q[W-2:0], bus.serialIn};
   // lrClk history tracks every bit slot, even while capture is disabled
   assign lr_prev_d  = bit_rise ? bus.lrClk : lr_prev_q;

   // State and datapath registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         bit_clk_q     <= 1'b0;
         lr_prev_q     <= LEFT_CHANNEL;
         cnt_q         <= '0;
         shift_q       <= '0;
         sample_q      <= '0;
         des_done_q    <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_clk_q     <= bus.bitClk;
         lr_prev_q     <= lr_prev_d;
         cnt_q         <= cnt_d;
         shift_q       <= shift_d;
         sample_q      <= sample_d;
         des_done_q    <= des_done_d;
         frame_error_q <= frame_error_d;
      end
   end

   // Next-state logic; dropping enable always returns to IDLE
   always_comb begin
      state_d = state_q;
      if (!bus.enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_WAIT;
            ST_WAIT:  if (frame_edge) state_d = ST_SKIP;
            ST_SKIP:  if (frame_edge) state_d = ST_SKIP;
                      else if (bit_rise) state_d = ST_SHIFT;
            ST_SHIFT: if (frame_edge) state_d = ST_SKIP;
                      else if (word_done) state_d = ST_WAIT;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath and pulse outputs; a disabled cycle silently drops the word
   always_comb begin
      cnt_d         = cnt_q;
      shift_d       = shift_q;
      sample_d      = sample_q;
      des_done_d    = 1'b0;
      frame_error_d = 1'b0;
      if (bus.enable) begin
         case (state_q)
            ST_WAIT: begin
               if (frame_edge) cnt_d = '0;
            end
            ST_SKIP: begin
               if (frame_edge) begin
                  frame_error_d = 1'b1;
                  cnt_d         = '0;
               end else if (bit_rise) begin
                  shift_d = W'(bus.serialIn);
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_SHIFT: begin
               if (frame_edge) begin
                  frame_error_d = 1'b1;
                  cnt_d         = '0;
               end else if (bit_rise) begin
                  shift_d = shifted;
                  cnt_d   = cnt_q + CNT_W'(1);
                  if (word_done) begin
                     sample_d   = shifted;
                     des_done_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sample     = sample_q;
   assign bus.desDone    = des_done_q;
   assign bus.frameError = frame_error_q;
endmodule

// File: tb/tb_audio_deserializer.sv
// Bench for audio_deserializer: instance a captures the left 16-bit word,
// instance b the right 24-bit word. A word-level reference model predicts
// every output cycle; directed phases add literal expectations.
module tb_audio_deserializer;
   localparam int WA = 16;
   localparam int WB = 24;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [1:0] en   = '0;
   logic [1:0] bclk = '0;
   logic [1:0] lr   = 2'b01;
   logic [1:0] sd   = '0;

   audio_deserializer_if #(.SAMPLE_WIDTH(WA)) bus_a ();
   audio_deserializer_if #(.SAMPLE_WIDTH(WB)) bus_b ();

   assign bus_a.enable   = en[0];
   assign bus_a.bitClk   = bclk[0];
   assign bus_a.lrClk    = lr[0];
   assign bus_a.serialIn = sd[0];
   assign bus_b.enable   = en[1];
   assign bus_b.bitClk   = bclk[1];
   assign bus_b.lrClk    = lr[1];
   assign bus_b.serialIn = sd[1];

   audio_deserializer #(.SAMPLE_WIDTH(WA), .LEFT_CHANNEL(1'b1)) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a.slave));
   audio_deserializer #(.SAMPLE_WIDTH(WB), .LEFT_CHANNEL(1'b0)) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b.slave));

   logic [31:0] act_sample [2];
   logic        act_done   [2];
   logic        act_err    [2];
   always_comb begin
      act_sample[0] = 32'(bus_a.sample);
      act_sample[1] = 32'(bus_b.sample);
      act_done[0]   = bus_a.desDone;
      act_done[1]   = bus_b.desDone;
      act_err[0]    = bus_a.frameError;
      act_err[1]    = bus_b.frameError;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (word level) ----------------
   // A capture-edge bit slot opens a word; the next W bit slots are its data.
   // Another capture edge while a word is open is an abort. The word is lost
   // silently if capture is not active (enable high this and last cycle).
   int          wid    [2] = '{WA, WB};
   logic        cap_lv [2] = '{1'b0, 1'b1};
   logic        m_valid = 1'b0;
   logic        m_prev_bclk [2];
   logic        m_prev_lr   [2];
   logic        m_en_prev   [2];
   logic        m_open      [2];
   int          m_nbits     [2];
   logic [31:0] m_acc       [2];
   logic [31:0] exp_sample  [2];
   logic        exp_done    [2];
   logic        exp_err     [2];
   int          done_cnt    [2] = '{0, 0};
   int          err_cnt     [2] = '{0, 0};
   int          cyc_n = 0;
   int          done_cyc_a [$];

   task automatic model_step(input int k);
      logic active, rise, edge_seen;
      if (reset) begin
         m_valid        = 1'b1;
         m_prev_bclk[k] = 1'b0;
         m_prev_lr[k]   = !cap_lv[k];
         m_en_prev[k]   = 1'b0;
         m_open[k]      = 1'b0;
         m_nbits[k]     = 0;
         m_acc[k]       = '0;
         exp_sample[k]  = '0;
         exp_done[k]    = 1'b0;
         exp_err[k]     = 1'b0;
         return;
      end
      active      = en[k] && m_en_prev[k];
      rise        = bclk[k] && !m_prev_bclk[k];
      edge_seen   = rise && (lr[k] != m_prev_lr[k]) && (lr[k] == cap_lv[k]);
      exp_done[k] = 1'b0;
      exp_err[k]  = 1'b0;
      if (!active) begin
         m_open[k] = 1'b0;
      end else if (edge_seen) begin
         exp_err[k] = m_open[k];
         m_open[k]  = 1'b1;
         m_nbits[k] = 0;
         m_acc[k]   = '0;
      end else if (rise && m_open[k]) begin
         m_acc[k] = {m_acc[k][30:0], sd[k]};
         m_nbits[k]++;
         if (m_nbits[k] == wid[k]) begin
            exp_sample[k] = m_acc[k];
            exp_done[k]   = 1'b1;
            m_open[k]     = 1'b0;
         end
      end
      if (rise) m_prev_lr[k] = lr[k];
      m_prev_bclk[k] = bclk[k];
      m_en_prev[k]   = en[k];
   endtask

   // Compare outputs of the last edge, then advance the model on the inputs
   // the next edge will sample.
   always @(negedge clock) begin
      cyc_n++;
      if (m_valid) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("desDone[%0d]", k), 32'(act_done[k]), 32'(exp_done[k]));
            check($sformatf("frameError[%0d]", k), 32'(act_err[k]), 32'(exp_err[k]));
            check($sformatf("sample[%0d]", k), act_sample[k], exp_sample[k]);
            if (act_done[k] === 1'b1) done_cnt[k]++;
            if (act_err[k] === 1'b1) err_cnt[k]++;
         end
         if (act_done[0] === 1'b1) done_cyc_a.push_back(cyc_n);
      end
      for (int k = 0; k < 2; k++) model_step(k);
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // One bit slot: BCLK low 4 clocks (data/lr change), then high 4 clocks.
   task automatic bit_slot(input int k, input logic lvl, input logic b);
      bclk[k] = 1'b0;
      lr[k]   = lvl;
      sd[k]   = b;
      cyc(4);
      bclk[k] = 1'b1;
      cyc(4);
   endtask

   // Slots first..last of an I2S frame whose first half carries the captured
   // word (lrClk at capture level) and second half the other channel.
   task automatic send_part(input int k, input logic [31:0] cap, input logic [31:0] oth,
                            input int first, input int last);
      int   w;
      logic lvl, b;
      w = wid[k];
      for (int i = first; i <= last; i++) begin
         lvl = (i < w) ? cap_lv[k] : !cap_lv[k];
         if (i == 0)       b = oth[0];
         else if (i <= w)  b = cap[w - i];
         else              b = oth[2 * w - i];
         bit_slot(k, lvl, b);
      end
   endtask

   task automatic send_frame(input int k, input logic [31:0] cap, input logic [31:0] oth);
      send_part(k, cap, oth, 0, 2 * wid[k] - 1);
   endtask

   int d0, e0, a, r;
   logic [31:0] w1, w2;

   initial begin
      // T1: reset with toggling inputs
      cyc(1);
      for (int i = 0; i < 3; i++) begin
         en   = 2'($urandom);
         bclk = 2'($urandom);
         lr   = 2'($urandom);
         sd   = 2'($urandom);
         cyc(1);
      end
      for (int k = 0; k < 2; k++) begin
         check($sformatf("reset_sample[%0d]", k), act_sample[k], 32'h0);
         check($sformatf("reset_desDone[%0d]", k), 32'(act_done[k]), 32'h0);
         check($sformatf("reset_frameError[%0d]", k), 32'(act_err[k]), 32'h0);
      end
      en = 2'b00; bclk = 2'b00; lr = 2'b01; sd = 2'b00;
      reset = 1'b0;
      cyc(2);

      // T2: single left word, right word never captured
      en[0] = 1'b1;
      bit_slot(0, 1'b1, 1'b0);
      bit_slot(0, 1'b1, 1'b1);
      d0 = done_cnt[0];
      send_frame(0, 32'hA5C3, 32'hFFFF);
      check("T2_sample", act_sample[0], 32'h0000_A5C3);
      check("T2_model_sample", exp_sample[0], 32'h0000_A5C3);
      check("T2_pulses", 32'(done_cnt[0] - d0), 32'd1);

      // T3: 8 back-to-back frames, 32 BCLK between pulses
      d0 = done_cnt[0];
      for (int n = 1; n <= 8; n++) begin
         send_frame(0, 32'h1111 * n, 32'hFFFF);
         check($sformatf("T3_sample_%0d", n), act_sample[0], 32'h1111 * n);
      end
      check("T3_pulses", 32'(done_cnt[0] - d0), 32'd8);
      for (int i = done_cyc_a.size() - 8; i < done_cyc_a.size(); i++)
         check($sformatf("T3_spacing_%0d", i), 32'(done_cyc_a[i] - done_cyc_a[i-1]), 32'd256);

      // T4: early frame edge after 5 bits, then a clean word
      d0 = done_cnt[0];
      e0 = err_cnt[0];
      send_part(0, 32'hBEEF, 32'h0, 0, 5);
      bit_slot(0, 1'b1, 1'b0);
      send_part(0, 32'h1234, 32'h5555, 0, 0);
      cyc(2);
      check("T4_err_pulses", 32'(err_cnt[0] - e0), 32'd1);
      check("T4_sample_held", act_sample[0], 32'h8888);
      send_part(0, 32'h1234, 32'h5555, 1, 31);
      check("T4_sample", act_sample[0], 32'h1234);
      check("T4_pulses", 32'(done_cnt[0] - d0), 32'd1);

      // T5: enable dropped at bit 9, raised mid-frame; next frame captured
      d0 = done_cnt[0];
      e0 = err_cnt[0];
      send_part(0, 32'h7E7E, 32'h3C3C, 0, 9);
      en[0] = 1'b0;
      send_part(0, 32'h7E7E, 32'h3C3C, 10, 19);
      en[0] = 1'b1;
      send_part(0, 32'h7E7E, 32'h3C3C, 20, 31);
      check("T5_no_pulse", 32'(done_cnt[0] - d0), 32'd0);
      check("T5_no_err", 32'(err_cnt[0] - e0), 32'd0);
      send_frame(0, 32'h8001, 32'h0F0F);
      check("T5_sample", act_sample[0], 32'h8001);

      // T6: right channel, 24 bits; reset in the middle of a second word
      en[1] = 1'b1;
      bit_slot(1, 1'b0, 1'b1);
      bit_slot(1, 1'b0, 1'b0);
      send_frame(1, 32'h80_0001, 32'($urandom) & 32'hFF_FFFF);
      check("T6_sample", act_sample[1], 32'h80_0001);
      d0 = done_cnt[1];
      send_part(1, 32'($urandom), 32'($urandom), 0, 12);
      cyc(2);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      check("T6_reset_sample", act_sample[1], 32'h0);
      check("T6_reset_pulse", 32'(done_cnt[1] - d0), 32'd0);
      cyc(4);

      // Randomised frames on both channels: clean words, aborts, enable glitches
      for (int it = 0; it < 16; it++) begin
         for (int k = 0; k < 2; k++) begin
            w1 = 32'($urandom);
            w2 = 32'($urandom);
            r  = $urandom_range(0, 3);
            if (r == 0) begin
               a = $urandom_range(1, wid[k] - 1);
               send_part(k, w1, w2, 0, a);
               bit_slot(k, !cap_lv[k], 1'($urandom));
            end else if (r == 1) begin
               a = $urandom_range(0, 2 * wid[k] - 1);
               send_part(k, w1, w2, 0, a);
               en[k] = 1'b0;
               cyc($urandom_range(1, 12));
               en[k] = 1'b1;
               if (a < 2 * wid[k] - 1) send_part(k, w1, w2, a + 1, 2 * wid[k] - 1);
            end else begin
               send_frame(k, w1, w2);
            end
         end
      end
      cyc(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
